// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and address-width helper.
package fifo_pkg;

   localparam bit FIFO_STD  = 1'b0;
   localparam bit FIFO_FWFT = 1'b1;

   // Address width for a given depth; a depth below two still gets one address bit
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: synchronous write port, asynchronous read port.
module fifo_mem #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Write port; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port, combinational from the address
   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through read,
// occupancy count, almost-full/empty thresholds, flush and sticky error flags.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 16,
   parameter bit          FWFT     = FIFO_STD,
   parameter int unsigned AF_LEVEL = 12,
   parameter int unsigned AE_LEVEL = 4,
   localparam int unsigned ADDR_W  = addr_width(DEPTH),
   localparam int unsigned CNT_W   = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] data_in,
   input  logic              rd_en,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [CNT_W-1:0]  count,
   output logic              overflow,
   output logic              underflow
);

   logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              dvalid_q, dvalid_d;

   logic              full_c;
   logic              empty_c;
   logic              wr_ok;
   logic              rd_ok;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] fwft_data;

   // Status decoded from the registered occupancy
   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign empty_c = (count_q == '0);

   // Accepted operations; flush takes priority over both requests
   assign wr_ok = wr_en & ~full_c  & ~clr;
   assign rd_ok = rd_en & ~empty_c & ~clr;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (rd_data)
   );

   // Next-state for pointers, occupancy, sticky errors and registered read data
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      dout_d      = dout_q;
      dvalid_d    = 1'b0;

      if (clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_en && full_c) begin
            overflow_d = 1'b1;
         end
         if (rd_en && empty_c) begin
            underflow_d = 1'b1;
         end
         if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + CNT_W'(1);
         end
         if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + CNT_W'(1);
            dout_d   = rd_data;
            dvalid_d = 1'b1;
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= '0;
         dvalid_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         dout_q      <= dout_d;
         dvalid_q    <= dvalid_d;
      end
   end

   // Fall-through head word, forced to zero while nothing is stored
   assign fwft_data = empty_c ? '0 : rd_data;

   assign data_out     = (FWFT == FIFO_FWFT) ? fwft_data : dout_q;
   assign data_valid   = (FWFT == FIFO_FWFT) ? ~empty_c  : dvalid_q;
   assign fifo_full    = full_c;
   assign fifo_empty   = empty_c;
   assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
   assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule
